// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtraction controller.
// The flag outputs of serial_sub_ctrl are built only when SERIAL_SUB_FLAGS_EN is defined.
package serial_sub_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_RUN  = 2'd1,
        SS_DONE = 2'd2
    } ss_state_e;

    // Largest operand width the controller is meant to be built with
    localparam int SS_MAX_WIDTH = 64;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: result = a - b - c_in, c_out = borrow out of this bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic result,
    output logic c_out
);

    // Purely combinational difference and borrow for a single bit position
    always_comb begin
        result = a ^ b ^ c_in;
        c_out  = (~a & (b | c_in)) | (b & c_in);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: drives one full_subtractor cell for WIDTH cycles, LSB first,
// to produce diff = a - b - borrow_in (mod 2^WIDTH) and the final borrow.
// Optional macro SERIAL_SUB_FLAGS_EN adds zero/negative/signed-overflow flags.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
`endif
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ss_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             brw_q, brw_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             cell_result;
    logic             cell_borrow;

`ifdef SERIAL_SUB_FLAGS_EN
    // z_acc ORs every result bit produced so far, so zero-detect costs one flop
    logic z_acc_q, z_acc_d;
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic flag_v_q, flag_v_d;
`endif

    // The single arithmetic element; fed from the low bits of the shift registers
    full_subtractor u_cell (
        .a      (a_sh_q[0]),
        .b      (b_sh_q[0]),
        .c_in   (brw_q),
        .result (cell_result),
        .c_out  (cell_borrow)
    );

    // Next-state logic for the FSM, counter, shifters and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        diff_sh_d    = diff_sh_q;
        brw_d        = brw_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
        z_acc_d      = z_acc_q;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        flag_v_d     = flag_v_q;
`endif
        case (state_q)
            SS_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_sh_d      = a;
                    b_sh_d      = b;
                    brw_d       = borrow_in;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    state_d     = SS_RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                    z_acc_d     = 1'b0;
`endif
                end
            end
            SS_RUN: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                diff_sh_d = {cell_result, diff_sh_q[WIDTH-1:1]};
                brw_d     = cell_borrow;
                cnt_d     = cnt_q + CNT_W'(1);
`ifdef SERIAL_SUB_FLAGS_EN
                z_acc_d   = z_acc_q | cell_result;
`endif
                if (cnt_q == LAST_BIT) begin
                    // Last bit: capture the completed result straight into the outputs
                    cnt_d        = '0;
                    diff_d       = diff_sh_d;
                    borrow_out_d = cell_borrow;
                    resp_valid_d = 1'b1;
                    state_d      = SS_DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                    // a_sh[0]/b_sh[0] now hold the sampled operand MSBs
                    flag_z_d = ~(z_acc_q | cell_result);
                    flag_n_d = cell_result;
                    flag_v_d = (a_sh_q[0] != b_sh_q[0]) && (cell_result != a_sh_q[0]);
`endif
                end
            end
            SS_DONE: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = SS_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = SS_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SS_IDLE;
            cnt_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            diff_sh_q    <= '0;
            brw_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            z_acc_q      <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            diff_sh_q    <= diff_sh_d;
            brw_q        <= brw_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_FLAGS_EN
            z_acc_q      <= z_acc_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_v     = flag_v_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus random operands
// checked against an arithmetic reference model. Flag checks compile in with SERIAL_SUB_FLAGS_EN.
module tb_serial_sub_ctrl;

    localparam int W = 8;
    localparam int TIMEOUT = 100;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [W-1:0] prev_diff;
    logic         prev_borrow;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .diff       (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
`endif
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the response, apply hold_cycles of backpressure, then accept.
    // keep_valid leaves req_valid high with scrambled operands while the operation runs.
    task automatic do_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic obin, input int hold_cycles, input bit keep_valid);
        int unsigned full;
        logic [W-1:0] exp_diff;
        logic         exp_brw;
        int           n;
        bit           stable;
        // Reference: plain integer subtraction with a borrow detected by magnitude compare
        full     = int'(oa) + (1 << W) - int'(ob) - int'(obin);
        exp_diff = W'(full);
        exp_brw  = (int'(oa) < int'(ob) + int'(obin));

        check({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; a = oa; b = ob; borrow_in = obin;
        tick();
        if (!keep_valid) req_valid = 1'b0;
        check({name, ".req_ready_run"}, 32'(req_ready), 32'd0);

        stable = 1'b1;
        n = 0;
        while (!resp_valid && n < TIMEOUT) begin
            if (keep_valid) begin
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            end
            tick();
            n++;
            if (!resp_valid && (diff !== prev_diff || borrow_out !== prev_borrow || req_ready !== 1'b0))
                stable = 1'b0;
        end
        check({name, ".latency"}, 32'(n), 32'(W));
        check({name, ".outputs_quiet_in_run"}, 32'(stable), 32'd1);
        if (n >= TIMEOUT) return;
        check({name, ".diff"}, 32'(diff), 32'(exp_diff));
        check({name, ".borrow_out"}, 32'(borrow_out), 32'(exp_brw));
`ifdef SERIAL_SUB_FLAGS_EN
        check({name, ".flag_z"}, 32'(flag_z), 32'(exp_diff == '0));
        check({name, ".flag_n"}, 32'(flag_n), 32'(exp_diff[W-1]));
        check({name, ".flag_v"}, 32'(flag_v), 32'((oa[W-1] != ob[W-1]) && (exp_diff[W-1] != oa[W-1])));
`endif
        stable = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            if (keep_valid) begin
                a = W'($urandom); b = W'($urandom);
            end
            tick();
            if (resp_valid !== 1'b1 || diff !== exp_diff || borrow_out !== exp_brw || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold_cycles > 0) check({name, ".held_under_backpressure"}, 32'(stable), 32'd1);

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check({name, ".resp_valid_dropped"}, 32'(resp_valid), 32'd0);
        check({name, ".req_ready_back"}, 32'(req_ready), 32'd1);
        prev_diff   = exp_diff;
        prev_borrow = exp_brw;
        $display("op %s: a=0x%02h b=0x%02h bin=%0d -> diff=0x%02h borrow=%0d (latency %0d)",
                 name, oa, ob, obin, diff, borrow_out, n);
    endtask

    initial begin
        bit quiet;
        rst = 1'b1; req_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; resp_ready = 1'b0;
        prev_diff = '0; prev_borrow = 1'b0;
        tick(); tick();
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.diff", 32'(diff), 32'd0);
        check("reset.borrow_out", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        tick();

        do_op("t1_simple", 8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op("t2_neg", 8'h03, 8'h05, 1'b0, 0, 1'b0);
        do_op("t3_borrow_in", 8'h00, 8'h00, 1'b1, 0, 1'b0);
        do_op("t3_overflow", 8'h80, 8'h01, 1'b0, 0, 1'b0);
        do_op("t4_backpressure", 8'hA5, 8'h3C, 1'b1, 5, 1'b0);
        do_op("t5_valid_held", 8'h42, 8'h17, 1'b0, 2, 1'b1);
        do_op("t5_next", 8'h11, 8'h22, 1'b0, 0, 1'b0);

        // Abort an operation three cycles into RUN
        req_valid = 1'b1; a = 8'h77; b = 8'h11; borrow_in = 1'b0;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("t6.reset_resp_valid", 32'(resp_valid), 32'd0);
        check("t6.reset_req_ready", 32'(req_ready), 32'd1);
        check("t6.reset_diff", 32'(diff), 32'd0);
        check("t6.reset_borrow_out", 32'(borrow_out), 32'd0);
        tick();
        rst = 1'b0;
        prev_diff = '0; prev_borrow = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        check("t6.no_response_after_abort", 32'(quiet), 32'd1);
        do_op("t6_fresh", 8'h10, 8'h01, 1'b0, 0, 1'b0);

        // Random operands with random backpressure
        for (int i = 0; i < 24; i++) begin
            do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. It sequences a single 1-bit full_subtractor cell over WIDTH cycles to compute a - b - borrow_in, LSB first. It sits beside the processor ALU as the area-minimal subtract/compare unit. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridable

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request operands valid
req_ready  output  1  controller can accept a request
a  input  WIDTH  minuend, sampled on request handshake
b  input  WIDTH  subtrahend, sampled on request handshake
borrow_in  input  1  initial borrow, sampled on request handshake
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  final borrow (1 = unsigned a < b + borrow_in)

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; resp_valid=0; diff=0; borrow_out=0; counter=0; shift regs=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, load a_sh=a, b_sh=b, brw=borrow_in, cnt=0; go to RUN.
  - RUN: req_ready=0. Each edge feeds a_sh[0], b_sh[0], brw to the cell. The cell result shifts into diff_sh MSB while diff_sh, a_sh and b_sh shift right by 1. brw takes the cell c_out and cnt increments. When cnt==WIDTH-1 on that edge, go to DONE.
  - DONE: resp_valid=1; diff=diff_sh; borrow_out=brw. Hold all outputs stable while resp_ready=0. On resp_valid&&resp_ready, go to IDLE and drop resp_valid.
- Latency: resp_valid rises exactly WIDTH edges after the accepting edge. A new request is accepted no earlier than the edge after the response handshake. Throughput is 1 op per WIDTH+2 cycles.
- req_ready is a registered function of state only and does not depend on req_valid. In RUN and DONE, req_valid is ignored and operands are not resampled.
- diff and borrow_out are registered and change only on entry to DONE or on reset.
- Arithmetic: pure unsigned borrow chain. No signed interpretation in base build. WIDTH-bit wrap is intended.
- Reset mid-RUN or mid-DONE aborts the operation. No response is produced and state is IDLE next cycle.
- Operand inputs changing during RUN have no effect.

Optional Feature:
SERIAL_SUB_FLAGS_EN
- Defined:
  - Adds outputs flag_z (diff==0), flag_n (diff[WIDTH-1]) and flag_v (signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB], using the sampled a and b MSBs).
  - flag_z is tracked serially as an OR-accumulator over result bits, not a WIDTH-wide compare.
  - Flags reset to 0, are registered together with diff on entry to DONE, and are held under backpressure.
- Undefined: the flag ports and their logic do not exist. Port list is exactly as above.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum ss_state_e {SS_IDLE, SS_RUN, SS_DONE}, 2-bit
  - localparam SS_MAX_WIDTH=64
- Sub-module: one instance of the existing full_subtractor cell (a, b, c_in -> result, c_out) as the sole arithmetic element. No other sub-modules; FSM, counter and shift registers are inline.

Test Plan:
(Bench WIDTH=8.)
1. a=0x05, b=0x03, borrow_in=0 -> resp_valid exactly 8 edges after accept; diff=0x02, borrow_out=0.
2. a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1. With flags: n=1, z=0, v=0.
3. a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1. Second case a=0x80, b=0x01 -> diff=0x7F; with flags v=1, n=0.
4. Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, diff and borrow_out stable, req_ready=0. Release -> IDLE one edge later, req_ready=1.
5. req_valid held high with changing a/b during RUN -> no resampling, result matches first operands. Next request is accepted only after the response handshake.
6. Assert rst 3 cycles into RUN -> outputs immediately at reset values. After release, no resp_valid appears; a fresh request (0x10 - 0x01) returns 0x0F.
